// File: rtl/cp0_core.sv
// cp0_core: MIPS32 CP0 register file with exception commit, Count/Compare timer and interrupt arbitration.
// Optional EBase register (reg 15 sel 1) enabled by defining CP0_EBASE_EN.
module cp0_core #(
  parameter int          HW_INT_N   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [2:0]          wsel,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  input  logic [2:0]          rsel,
  output logic [31:0]         rdata,
  input  logic [HW_INT_N-1:0] hw_int,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic [31:0]         exc_badva,
  input  logic                eret,
  output logic                int_pending,
  output logic [31:0]         exc_target,
  output logic [31:0]         status,
  output logic [31:0]         cause,
  output logic [31:0]         epc,
  output logic                timer_int
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0]       r_pre;
  logic [31:0]         r_count, r_compare, r_epc, r_badva;
  logic                r_timer, r_exl, r_ie, r_bd;
  logic [7:0]          r_im;
  logic [1:0]          r_ipsw;
  logic [4:0]          r_code;
  logic [HW_INT_N-1:0] r_hw;
  logic [5:0]          w_hw6;
  logic [7:0]          w_ip;
  logic                w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc, w_tick, w_epc_upd;

  assign w_wr_count   = we && waddr == 5'd9  && wsel == 3'd0;
  assign w_wr_compare = we && waddr == 5'd11 && wsel == 3'd0;
  assign w_wr_status  = we && waddr == 5'd12 && wsel == 3'd0;
  assign w_wr_cause   = we && waddr == 5'd13 && wsel == 3'd0;
  assign w_wr_epc     = we && waddr == 5'd14 && wsel == 3'd0;
  // A Count write restarts the prescaler, so it also suppresses this cycle's tick
  assign w_tick       = !w_wr_count && r_pre == PRE_MAX;
  assign w_epc_upd    = exc_valid && !r_exl;
  assign w_hw6        = 6'(r_hw);
  assign w_ip         = {w_hw6[5] | r_timer, w_hw6[4:0], r_ipsw};

  assign status      = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign cause       = {r_bd, r_timer, 14'b0, w_ip, 1'b0, r_code, 2'b0};
  assign epc         = r_epc;
  assign timer_int   = r_timer;
  assign int_pending = r_ie && !r_exl && |(w_ip & r_im);

`ifdef CP0_EBASE_EN
  logic [17:0] r_ebase;
  logic [31:0] w_ebase;
  assign w_ebase    = {2'b10, r_ebase, 12'b0};
  assign exc_target = w_ebase + 32'h180;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ebase <= '0;
    else if (we && waddr == 5'd15 && wsel == 3'd1) r_ebase <= wdata[29:12];
`else
  logic [31:0] w_ebase;
  assign w_ebase    = '0;
  assign exc_target = EXC_VECTOR;
`endif

  always_comb begin
    rdata = '0;
    case ({raddr, rsel})
      {5'd8,  3'd0}: rdata = r_badva;
      {5'd9,  3'd0}: rdata = r_count;
      {5'd11, 3'd0}: rdata = r_compare;
      {5'd12, 3'd0}: rdata = status;
      {5'd13, 3'd0}: rdata = cause;
      {5'd14, 3'd0}: rdata = r_epc;
      {5'd15, 3'd0}: rdata = PRID_VAL;
      {5'd15, 3'd1}: rdata = w_ebase;
      {5'd16, 3'd0}: rdata = 32'h0000_8000;
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_timer   <= 1'b0;
      r_hw      <= '0;
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_ipsw    <= '0;
      r_code    <= '0;
      r_bd      <= 1'b0;
      r_epc     <= '0;
      r_badva   <= '0;
    end else begin
      r_pre     <= (w_wr_count || w_tick) ? '0 : r_pre + 1'b1;
      r_count   <= w_wr_count ? wdata : r_count + {31'b0, w_tick};
      r_compare <= w_wr_compare ? wdata : r_compare;
      r_timer   <= w_wr_compare ? 1'b0 : (w_tick && r_count == r_compare) ? 1'b1 : r_timer;
      r_hw      <= hw_int;
      r_im      <= w_wr_status ? wdata[15:8] : r_im;
      r_ie      <= w_wr_status ? wdata[0] : r_ie;
      r_exl     <= exc_valid ? 1'b1 : eret ? 1'b0 : w_wr_status ? wdata[1] : r_exl;
      r_ipsw    <= w_wr_cause ? wdata[9:8] : r_ipsw;
      r_code    <= exc_valid ? exc_code : r_code;
      r_bd      <= w_epc_upd ? exc_bd : r_bd;
      r_epc     <= w_epc_upd ? (exc_bd ? exc_pc - 32'd4 : exc_pc) : w_wr_epc ? wdata : r_epc;
      r_badva   <= (exc_valid && (exc_code == 5'd4 || exc_code == 5'd5)) ? exc_badva : r_badva;
    end
  end
endmodule

// File: tb/tb_cp0_core.sv
// tb_cp0_core: directed self-checking bench for cp0_core with hand-computed expectations.
module tb_cp0_core;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0, exc_valid = 1'b0, exc_bd = 1'b0, eret = 1'b0;
  logic [4:0]  waddr = '0, raddr = '0, exc_code = '0;
  logic [2:0]  wsel = '0, rsel = '0;
  logic [31:0] wdata = '0, exc_pc = '0, exc_badva = '0;
  logic [5:0]  hw_int = '0;
  logic [31:0] rdata, exc_target, status, cause, epc;
  logic        int_pending, timer_int;
  int          n_chk = 0, n_pass = 0;

  cp0_core dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva(exc_badva), .eret(eret), .int_pending(int_pending), .exc_target(exc_target),
    .status(status), .cause(cause), .epc(epc), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    we = 1'b1; waddr = a; wsel = s; wdata = d;
    step(1);
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [2:0] s, input logic [31:0] exp);
    raddr = a; rsel = s;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic exc(input logic [4:0] c, input logic [31:0] pc, input logic bd, input logic [31:0] va, input logic er);
    exc_valid = 1'b1; exc_code = c; exc_pc = pc; exc_bd = bd; exc_badva = va; eret = er;
    step(1);
    exc_valid = 1'b0; eret = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_status", status, 32'h0040_0000);
    chk("rst_cause", cause, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_timer", {31'b0, timer_int}, 32'h0);
    chk("rst_intp", {31'b0, int_pending}, 32'h0);
    rd("rst_count", 5'd9, 3'd0, 32'h0);
    rd("prid", 5'd15, 3'd0, 32'h004C0102);
    rd("config", 5'd16, 3'd0, 32'h0000_8000);
    rd("unused_reg", 5'd10, 3'd0, 32'h0);
    // T1: count prescale and wrap; Count==Compare==0 at the first tick sets the timer
    step(10);
    rd("count_10cyc", 5'd9, 3'd0, 32'd5);
    chk("timer_zero_cmp", {31'b0, timer_int}, 32'h1);
    wr(5'd9, 3'd0, 32'hFFFF_FFFF);
    rd("count_load", 5'd9, 3'd0, 32'hFFFF_FFFF);
    step(1);
    rd("count_hold", 5'd9, 3'd0, 32'hFFFF_FFFF);
    step(1);
    rd("count_wrap", 5'd9, 3'd0, 32'h0);
    // T2: timer match and clear
    wr(5'd11, 3'd0, 32'd8);
    chk("timer_clr", {31'b0, timer_int}, 32'h0);
    wr(5'd12, 3'd0, 32'h0000_8001);
    wr(5'd9, 3'd0, 32'd6);
    step(5);
    chk("timer_early", {31'b0, timer_int}, 32'h0);
    chk("intp_early", {31'b0, int_pending}, 32'h0);
    step(1);
    chk("timer_set", {31'b0, timer_int}, 32'h1);
    chk("intp_timer", {31'b0, int_pending}, 32'h1);
    chk("cause_ti", cause, 32'h4000_8000);
    wr(5'd11, 3'd0, 32'd100);
    chk("timer_clr2", {31'b0, timer_int}, 32'h0);
    chk("intp_clr", {31'b0, int_pending}, 32'h0);
    // T3: AdEL in delay slot
    exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h1003, 1'b0);
    chk("t3_epc", epc, 32'hBFC0_0100);
    chk("t3_cause", cause, 32'h8000_0010);
    chk("t3_status", status, 32'h0040_8003);
    rd("t3_badva", 5'd8, 3'd0, 32'h1003);
    // T4: nested exception keeps EPC/BD, then eret
    exc(5'd8, 32'h200, 1'b0, 32'h5555, 1'b0);
    chk("t4_epc", epc, 32'hBFC0_0100);
    chk("t4_cause", cause, 32'h8000_0020);
    rd("t4_badva", 5'd8, 3'd0, 32'h1003);
    eret = 1'b1; step(1); eret = 1'b0;
    chk("t4_eret", status, 32'h0040_8001);
    // T5: hardware interrupt with one-cycle latency, masked by EXL
    wr(5'd12, 3'd0, 32'h0000_0401);
    hw_int = 6'b000001;
    #1;
    chk("t5_lat", {31'b0, int_pending}, 32'h0);
    step(1);
    chk("t5_intp", {31'b0, int_pending}, 32'h1);
    chk("t5_cause", cause, 32'h8000_0420);
    wr(5'd12, 3'd0, 32'h0000_0403);
    chk("t5_exl_mask", {31'b0, int_pending}, 32'h0);
    // write masks
    wr(5'd13, 3'd0, 32'hFFFF_FFFF);
    chk("cause_mask", cause, 32'h8000_0720);
    wr(5'd12, 3'd0, 32'hFFFF_FFFF);
    chk("status_mask", status, 32'h0040_FF03);
    wr(5'd15, 3'd0, 32'h1234_5678);
    rd("prid_ro", 5'd15, 3'd0, 32'h004C0102);
    wr(5'd8, 3'd0, 32'h1234_5678);
    rd("badva_ro", 5'd8, 3'd0, 32'h1003);
    eret = 1'b1; step(1); eret = 1'b0;
    chk("eret2", status, 32'h0040_FF01);
    chk("intp_sw_hw", {31'b0, int_pending}, 32'h1);
    // exception beats eret in the same cycle
    exc(5'd0, 32'h300, 1'b0, 32'h0, 1'b1);
    chk("exc_eret_st", status, 32'h0040_FF03);
    chk("exc_eret_epc", epc, 32'h300);
    chk("exc_eret_cause", cause, 32'h0000_0700);
    // mfc0 sees the pre-write value
    we = 1'b1; waddr = 5'd14; wsel = 3'd0; wdata = 32'hDEAD_0000;
    rd("rd_before_wr", 5'd14, 3'd0, 32'h300);
    step(1);
    we = 1'b0;
    chk("epc_write", epc, 32'hDEAD_0000);
`ifdef CP0_EBASE_EN
    rd("ebase_rst", 5'd15, 3'd1, 32'h8000_0000);
    wr(5'd15, 3'd1, 32'h8001_0000);
    chk("ebase_target", exc_target, 32'h8001_0180);
    wr(5'd15, 3'd1, 32'hFFFF_FFFF);
    rd("ebase_mask", 5'd15, 3'd1, 32'hBFFF_F000);
`else
    chk("exc_target", exc_target, 32'hBFC0_0380);
    wr(5'd15, 3'd1, 32'h8001_0000);
    rd("ebase_absent", 5'd15, 3'd1, 32'h0);
`endif
    // asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("arst_status", status, 32'h0040_0000);
    chk("arst_epc", epc, 32'h0);
    rd("arst_count", 5'd9, 3'd0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
